// File: rtl/seq_mult.sv
// Shift-and-add unsigned multiplier (IDLE/RUN/DONE) with a valid/ready handshake on both sides.
// Define SEQ_MULT_EARLY_EXIT_EN to finish as soon as the remaining multiplier bits are all zero.

module addern #(
    parameter int N = 8
) (
    input  logic [N-1:0] i_a,
    input  logic [N-1:0] i_b,
    input  logic         i_cin,
    output logic [N-1:0] o_sum,
    output logic         o_cout
);
    logic [N:0] w_c;

    assign w_c[0] = i_cin;

    for (genvar i = 0; i < N; i++) begin : g_fa
        assign o_sum[i]  = i_a[i] ^ i_b[i] ^ w_c[i];
        assign w_c[i+1]  = (i_a[i] & i_b[i]) | (w_c[i] & (i_a[i] ^ i_b[i]));
    end

    assign o_cout = w_c[N];
endmodule

module seq_mult #(
    parameter int N = 8
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [N-1:0]   a,
    input  logic [N-1:0]   b,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [2*N-1:0] product
);
    localparam int CW = $clog2(N);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t          r_state;
    state_t          w_next;
    logic [N-1:0]    r_mcand;
    logic [N-1:0]    r_hi;
    logic [N-1:0]    r_lo;
    logic [CW-1:0]   r_cnt;

    logic [N-1:0]    w_addend;
    logic [N-1:0]    w_sum;
    logic            w_cout;
    logic [2*N-1:0]  w_step;
    logic [2*N-1:0]  w_result;
    logic            w_last;

    // Adding zero when lo[0]=0 yields {0,hi}, so one adder covers both cases.
    assign w_addend = r_lo[0] ? r_mcand : '0;

    addern #(.N(N)) u_add (
        .i_a    (r_hi),
        .i_b    (w_addend),
        .i_cin  (1'b0),
        .o_sum  (w_sum),
        .o_cout (w_cout)
    );

    assign w_step = {w_cout, w_sum, r_lo[N-1:1]};

`ifdef SEQ_MULT_EARLY_EXIT_EN
    logic w_rem_zero;

    // Unconsumed multiplier bits sit at lo[1 .. N-1-cnt]; the upper bits already hold product.
    always_comb begin
        w_rem_zero = 1'b1;
        for (int i = 1; i < N; i++) begin
            if (i <= N - 1 - int'(r_cnt)) begin
                w_rem_zero = w_rem_zero & ~r_lo[i];
            end
        end
    end

    // Apply the skipped no-add steps in one go so the product lands in its final position.
    assign w_result = w_step >> (N - 1 - int'(r_cnt));
    assign w_last   = w_rem_zero || (r_cnt == CW'(N - 1));
`else
    assign w_result = w_step;
    assign w_last   = (r_cnt == CW'(N - 1));
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (in_valid)  w_next = S_RUN;
            S_RUN:   if (w_last)    w_next = S_DONE;
            S_DONE:  if (out_ready) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mcand <= '0;
            r_hi    <= '0;
            r_lo    <= '0;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        r_mcand <= a;
                        r_lo    <= b;
                        r_hi    <= '0;
                        r_cnt   <= '0;
                    end
                end
                S_RUN: begin
                    {r_hi, r_lo} <= w_result;
                    r_cnt        <= r_cnt + CW'(1);
                end
                default: ;
            endcase
        end
    end

    assign in_ready  = (r_state == S_IDLE);
    assign out_valid = (r_state == S_DONE);
    assign product   = {r_hi, r_lo};
endmodule

// File: tb/tb_seq_mult.sv
// Scoreboard bench for seq_mult: driver pushes expected product/latency, monitor pops on out_valid.
// Latency expectation follows SEQ_MULT_EARLY_EXIT_EN when the bench is built with it.

module tb_seq_mult;
    localparam int N = 8;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           in_valid = 1'b0;
    logic           in_ready;
    logic [N-1:0]   a = '0;
    logic [N-1:0]   b = '0;
    logic           out_valid;
    logic           out_ready = 1'b0;
    logic [2*N-1:0] product;

    seq_mult #(.N(N)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .product   (product)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        logic [2*N-1:0] prod;
        int             lat;
        int             acc;
        int             hold;
    } exp_t;

    exp_t sb[$];
    exp_t cur;
    bit   in_done = 1'b0;
    bit   spurious = 1'b0;
    int   done_cyc = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference latency: N steps, or with early exit one step per bit up to the top set bit of b.
    function automatic int exp_lat(input logic [N-1:0] mb);
`ifdef SEQ_MULT_EARLY_EXIT_EN
        int k;
        k = 0;
        for (int i = 0; i < N; i++) if (mb[i]) k = i;
        return k + 1;
`else
        return N;
`endif
    endfunction

    // Monitor: checks every DONE period against the head of the scoreboard.
    always @(negedge clk) begin
        if (!rst_n) begin
            in_done   = 1'b0;
            out_ready = 1'b0;
        end else if (out_valid) begin
            if (!in_done) begin
                in_done  = 1'b1;
                done_cyc = 0;
                if (sb.size() == 0) begin
                    spurious = 1'b1;
                    cur      = '{prod: '0, lat: 0, acc: 0, hold: 0};
                    chk("spurious_out_valid", 1, 0);
                end else begin
                    spurious = 1'b0;
                    cur      = sb.pop_front();
                    chk("product", product, cur.prod);
                    chk("latency", cyc - cur.acc, cur.lat);
                end
            end else if (!spurious) begin
                chk("product_stable", product, cur.prod);
            end
            chk("in_ready_in_done", in_ready, 0);
            out_ready = (done_cyc >= cur.hold);
            done_cyc++;
        end else begin
            if (in_done) begin
                chk("done_cycles", done_cyc, cur.hold + 1);
                in_done = 1'b0;
            end
            out_ready = 1'($urandom_range(0, 1));
        end
    end

    // Called at a negedge; holds in_valid high until the block is ready, so a wrongly early
    // acceptance would desynchronise the scoreboard.
    task automatic submit(input logic [N-1:0] ta, input logic [N-1:0] tb_, input int hold);
        int w;
        logic [2*N-1:0] p;
        w = 0;
        a = ta;
        b = tb_;
        in_valid = 1'b1;
        while (!in_ready && w < 200) begin
            @(negedge clk);
            w++;
        end
        if (!in_ready) begin
            chk("accept_timeout", 0, 1);
            in_valid = 1'b0;
            return;
        end
        p = {{N{1'b0}}, ta} * {{N{1'b0}}, tb_};
        sb.push_back('{prod: p, lat: exp_lat(tb_), acc: cyc + 1, hold: hold});
        @(negedge clk);
        in_valid = 1'b0;
        a = N'($urandom);
        b = N'($urandom);
    endtask

    task automatic drain();
        int w;
        w = 0;
        while ((sb.size() != 0 || in_done) && w < 500) begin
            @(negedge clk);
            w++;
        end
        if (sb.size() != 0 || in_done) chk("drain_timeout", 0, 1);
    endtask

    initial begin
        #3;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_product", product, 0);

        @(negedge clk);
        rst_n = 1'b1;
        submit(8'd3, 8'd5, 0);
        submit(8'd255, 8'd255, 0);
        submit(8'hA5, 8'h00, 0);
        submit(8'd12, 8'd10, 5);
        submit(8'd7, 8'd1, 0);
        submit(8'd7, 8'h80, 0);
        submit(8'd0, 8'd0, 0);
        submit(8'd255, 8'd1, 2);
        for (int i = 0; i < 40; i++) begin
            submit(N'($urandom), N'($urandom >> $urandom_range(0, 7)), $urandom_range(0, 3));
        end
        drain();

        // Abort mid-RUN at cnt=4.
        submit(8'hC3, 8'hFF, 0);
        repeat (4) @(negedge clk);
        chk("run_in_ready", in_ready, 0);
        #2 rst_n = 1'b0;
        #1;
        chk("abort_out_valid", out_valid, 0);
        chk("abort_product", product, 0);
        chk("abort_in_ready", in_ready, 1);
        sb.delete();
        @(negedge clk);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        chk("post_abort_in_ready", in_ready, 1);

        // Acceptance on the first edge after reset release.
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        submit(8'd9, 8'd9, 0);
        submit(8'd200, 8'd3, 1);
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/seq_mult.md
SEQ_MULT -- requirements
Module: seq_mult

Interface
REQ-001 SHALL have parameter N, default 8: operand width in bits, N >= 2.
REQ-002 SHALL have port clk, input, 1: single clock; all state changes on rising edge.
REQ-003 SHALL have port rst_n, input, 1: reset, asynchronous, active-low.
REQ-004 SHALL have port in_valid, input, 1: operands a/b valid.
REQ-005 SHALL have port in_ready, output, 1: block accepts operands; high only in IDLE.
REQ-006 SHALL have port a, input, N: multiplicand, unsigned.
REQ-007 SHALL have port b, input, N: multiplier, unsigned.
REQ-008 SHALL have port out_valid, output, 1: product valid; high only in DONE.
REQ-009 SHALL have port out_ready, input, 1: consumer accepts product.
REQ-010 SHALL have port product, output, 2N: unsigned a*b.

Function
REQ-011 SHALL implement a shift-and-add multiplier with states IDLE, RUN, DONE.
REQ-012 SHALL perform every partial-sum addition through one instance of the team's N-bit ripple adder addern, with cin tied to 0.
- No other adder on the datapath.
REQ-013 SHALL accept operands at an edge where in_valid && in_ready.
- Latch mcand=a, lo=b, hi=0, cnt=0.
- Next state RUN.
REQ-014 SHALL, on each RUN edge, update the datapath as follows:
- If lo[0]=1, {c,sum} = hi + mcand; otherwise {c,sum} = {0,hi}.
- {hi,lo} <= {c,sum,lo[N-1:1]}.
- cnt increments.
REQ-015 SHALL move RUN->DONE on the edge that performs step cnt==N-1.
- Exactly N RUN edges.
- out_valid rises N cycles after the acceptance edge.
REQ-016 SHALL drive product = {hi,lo}, held stable throughout DONE regardless of inputs.
REQ-017 SHALL hold DONE while out_ready=0.
- DONE->IDLE on the edge with out_valid && out_ready.
REQ-018 SHALL keep in_ready=0 in RUN and DONE.
- No new acceptance on the DONE->IDLE edge; earliest next acceptance is one cycle later.
REQ-019 SHALL compute carries into hi without truncation: 255*255 = 65025 at N=8.
REQ-020 SHALL ignore a, b and in_valid outside IDLE.
REQ-021 SHALL ignore out_ready outside DONE.

Reset
REQ-022 SHALL, while rst_n=0 and independent of clk, force:
- state=IDLE
- cnt=0, hi=0, lo=0, mcand=0
- product=0, out_valid=0, in_ready=1
REQ-023 SHALL abort any RUN or DONE operation on reset, discarding it.
- No out_valid for the aborted operation after release.
REQ-024 SHALL accept operands on the first rising edge after rst_n deasserts, if in_valid=1.

Configuration
REQ-025 SHALL support macro SEQ_MULT_EARLY_EXIT_EN.
REQ-026 SHALL behave as follows with SEQ_MULT_EARLY_EXIT_EN defined:
- On a RUN edge, if the not-yet-consumed multiplier bits (lo[N-1:1] of the pre-shift lo, restricted to the N-1-cnt remaining positions) are all zero, finish in that edge.
- {hi,lo} is shifted right by the remaining count so the result is exact.
- Next state DONE.
- Latency = 1 + index of the highest set bit of b; b=0 gives latency 1.
REQ-027 SHALL, without SEQ_MULT_EARLY_EXIT_EN, have fixed latency of N cycles and contain no early-exit logic.

Verification
REQ-028 SHALL check, N=8: a=3, b=5, out_ready=1 -> product=15, out_valid exactly 8 cycles after acceptance (macro off).
REQ-029 SHALL check: a=255, b=255 -> product=65025 (0xFE01), no carry loss.
REQ-030 SHALL check: a=0xA5, b=0 -> product=0.
- Macro off: out_valid after 8 cycles.
- Macro on: out_valid after 1 cycle.
REQ-031 SHALL check: a=12, b=10, out_ready=0 for 5 cycles after out_valid -> product=120 stable, in_ready=0 throughout.
- IDLE one edge after out_ready=1.
REQ-032 SHALL check: rst_n pulsed low mid-RUN (cnt=4) -> immediate out_valid=0, product=0, in_ready=1.
- No stale result after release.
REQ-033 SHALL check, macro on: a=7, b=1 -> product=7, out_valid 1 cycle after acceptance.
- a=7, b=0x80 -> product=896, out_valid 8 cycles after acceptance.
